// File: rtl/point_in_triangle.sv
// Edge-function inside test for a hit point against a triangle, Q16.16 signed.
// One shared 32x32 multiplier runs 9 steps per edge: 6 cross-product terms, then 3 dot-product terms.
module point_in_triangle #(
    parameter int FRAC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] p_hit0,
    input  logic [31:0] p_hit1,
    input  logic [31:0] p_hit2,
    input  logic [31:0] v0_0,
    input  logic [31:0] v0_1,
    input  logic [31:0] v0_2,
    input  logic [31:0] v1_0,
    input  logic [31:0] v1_1,
    input  logic [31:0] v1_2,
    input  logic [31:0] v2_0,
    input  logic [31:0] v2_1,
    input  logic [31:0] v2_2,
    input  logic [31:0] normal0,
    input  logic [31:0] normal1,
    input  logic [31:0] normal2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        hit,
    output logic        degenerate
);

    typedef logic [2:0][31:0] vec_t;

    typedef struct packed {
        vec_t p;
        vec_t v0;
        vec_t v1;
        vec_t v2;
        vec_t n;
    } tri_req_t;

    typedef enum logic [1:0] {IDLE, EDGE, DONE} state_t;

    state_t          state, state_nxt;
    tri_req_t        ops, req;
    logic [1:0]      edge_idx;
    logic [3:0]      step_cnt;
    vec_t            s_acc;
    logic [65:0]     d_acc;
    logic [1:0]      zero_flags;

    vec_t            a, b, e, c;
    logic signed [31:0] mul_a, mul_b;
    logic signed [63:0] prod;
    logic [31:0]     prod_q;
    logic [65:0]     prod_ext, d_fin;
    logic            last_step, d_neg, d_zero;

    assign req = '{p:  {p_hit2, p_hit1, p_hit0},
                   v0: {v0_2, v0_1, v0_0},
                   v1: {v1_2, v1_1, v1_0},
                   v2: {v2_2, v2_1, v2_0},
                   n:  {normal2, normal1, normal0}};

    // Edge endpoints and wrapping differences, derived from the captured operands
    always_comb begin
        a = ops.v2;
        b = ops.v0;
        unique case (edge_idx)
            2'd0: begin a = ops.v0; b = ops.v1; end
            2'd1: begin a = ops.v1; b = ops.v2; end
            default: begin a = ops.v2; b = ops.v0; end
        endcase
        for (int i = 0; i < 3; i++) begin
            e[i] = b[i] - a[i];
            c[i] = ops.p[i] - a[i];
        end
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (step_cnt)
            4'd0: begin mul_a = e[1];     mul_b = c[2];     end
            4'd1: begin mul_a = e[2];     mul_b = c[1];     end
            4'd2: begin mul_a = e[2];     mul_b = c[0];     end
            4'd3: begin mul_a = e[0];     mul_b = c[2];     end
            4'd4: begin mul_a = e[0];     mul_b = c[1];     end
            4'd5: begin mul_a = e[1];     mul_b = c[0];     end
            4'd6: begin mul_a = ops.n[0]; mul_b = s_acc[0]; end
            4'd7: begin mul_a = ops.n[1]; mul_b = s_acc[1]; end
            4'd8: begin mul_a = ops.n[2]; mul_b = s_acc[2]; end
            default: begin mul_a = '0;    mul_b = '0;       end
        endcase
    end

    assign prod      = mul_a * mul_b;
    assign prod_q    = prod[FRAC+31:FRAC];
    assign prod_ext  = {{2{prod[63]}}, prod};
    assign d_fin     = d_acc + prod_ext;
    assign d_neg     = d_fin[65];
    assign d_zero    = (d_fin == '0);
    assign last_step = (state == EDGE) && (step_cnt == 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = EDGE;
            EDGE: if (last_step && (d_neg || edge_idx == 2'd2)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops        <= '0;
            edge_idx   <= '0;
            step_cnt   <= '0;
            s_acc      <= '0;
            d_acc      <= '0;
            zero_flags <= '0;
            hit        <= 1'b0;
            degenerate <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    ops        <= req;
                    edge_idx   <= '0;
                    step_cnt   <= '0;
                    zero_flags <= '0;
                    hit        <= 1'b0;
                    degenerate <= 1'b0;
                end
                EDGE: begin
                    step_cnt <= step_cnt + 4'd1;
                    unique case (step_cnt)
                        4'd0: s_acc[0] <= prod_q;
                        4'd1: s_acc[0] <= s_acc[0] - prod_q;
                        4'd2: s_acc[1] <= prod_q;
                        4'd3: s_acc[1] <= s_acc[1] - prod_q;
                        4'd4: s_acc[2] <= prod_q;
                        4'd5: s_acc[2] <= s_acc[2] - prod_q;
                        4'd6: d_acc    <= prod_ext;
                        4'd7: d_acc    <= d_fin;
                        4'd8: begin
                            step_cnt <= '0;
                            d_acc    <= '0;
                            if (d_neg) begin
                                hit        <= 1'b0;
                                degenerate <= 1'b0;
                            end else if (edge_idx != 2'd2) begin
                                zero_flags[edge_idx[0]] <= d_zero;
                                edge_idx <= edge_idx + 2'd1;
                            end else begin
                                degenerate <= &zero_flags & d_zero;
                                hit        <= ~(&zero_flags & d_zero);
                            end
                        end
                        default: step_cnt <= '0;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_point_in_triangle.sv
// Scoreboarded bench for point_in_triangle: directed boundary cases, random points, backpressure, reset abort.
module tb_point_in_triangle;

    typedef logic [2:0][31:0] vec_t;
    typedef struct {
        bit    h;
        bit    dg;
        int    lat;
        string name;
    } exp_t;

    localparam logic [31:0] ONE = 32'h0001_0000;
    localparam logic [31:0] HLF = 32'h0000_8000;
    localparam logic [31:0] QTR = 32'h0000_4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, hit, degenerate;
    vec_t p, v0, v1, v2, n;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    point_in_triangle #(.FRAC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .p_hit0(p[0]), .p_hit1(p[1]), .p_hit2(p[2]),
        .v0_0(v0[0]), .v0_1(v0[1]), .v0_2(v0[2]),
        .v1_0(v1[0]), .v1_1(v1[1]), .v1_2(v1[2]),
        .v2_0(v2[0]), .v2_1(v2[1]), .v2_2(v2[2]),
        .normal0(n[0]), .normal1(n[1]), .normal2(n[2]),
        .out_valid(out_valid), .out_ready(out_ready),
        .hit(hit), .degenerate(degenerate)
    );

    function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return {z, y, x};
    endfunction

    function automatic logic signed [31:0] fx(input logic signed [31:0] x, input logic signed [31:0] y);
        logic signed [63:0] pr;
        pr = x * y;
        return pr[47:16];
    endfunction

    // Reference: full cross/dot per edge, early exit on a negative edge
    function automatic void model(input vec_t pp, input vec_t a0, input vec_t a1, input vec_t a2,
                                  input vec_t nn, output bit h, output bit dg, output int lat);
        vec_t vs[3];
        logic signed [31:0] e[3], c[3], s[3];
        logic signed [63:0] t;
        logic signed [65:0] d;
        bit zero[3];
        vs[0] = a0; vs[1] = a1; vs[2] = a2;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                e[i] = vs[(k + 1) % 3][i] - vs[k][i];
                c[i] = pp[i] - vs[k][i];
            end
            s[0] = fx(e[1], c[2]) - fx(e[2], c[1]);
            s[1] = fx(e[2], c[0]) - fx(e[0], c[2]);
            s[2] = fx(e[0], c[1]) - fx(e[1], c[0]);
            d = '0;
            for (int i = 0; i < 3; i++) begin
                t = $signed(nn[i]) * s[i];
                d = d + t;
            end
            if (d < 0) begin
                h = 1'b0; dg = 1'b0; lat = 9 * (k + 1);
                return;
            end
            zero[k] = (d == 0);
        end
        dg = zero[0] && zero[1] && zero[2];
        h = !dg;
        lat = 27;
    endfunction

    // One transaction: push expectation, accept, count latency, pop and compare, optional stall
    task automatic do_txn(input vec_t pp, input vec_t a0, input vec_t a1, input vec_t a2, input vec_t nn,
                          input bit eh, input bit ed, input int el, input string name,
                          input int hold, input bit poke);
        exp_t ex;
        int cyc;
        bit busy_ok;
        logic h0, d0;
        sb.push_back('{h: eh, dg: ed, lat: el, name: name});
        @(negedge clk);
        p = pp; v0 = a0; v1 = a1; v2 = a2; n = nn;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && cyc < 60) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            if (poke && cyc == 3) begin in_valid = 1'b1; p = mk(ONE * 5, ONE * 5, 0); end
            if (poke && cyc == 4) in_valid = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        ex = sb.pop_front();
        if (cyc >= 60) begin
            checks++; errors++;
            $display("FAIL %s timeout: no out_valid within 60 cycles", ex.name);
            return;
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy: in_ready rose during computation", ex.name);
        end
        checks++;
        if (hit !== ex.h || degenerate !== ex.dg || cyc !== ex.lat) begin
            errors++;
            $display("FAIL %s result: hit=%b deg=%b lat=%0d required hit=%b deg=%b lat=%0d",
                     ex.name, hit, degenerate, cyc, ex.h, ex.dg, ex.lat);
        end
        h0 = hit; d0 = degenerate;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || hit !== h0 || degenerate !== d0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s stall%0d: ov=%b hit=%b deg=%b ir=%b required 1 %b %b 0",
                         ex.name, i, out_valid, hit, degenerate, in_ready, h0, d0);
            end
        end
        out_ready = 1'b1;
        in_valid = poke;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: ov=%b ir=%b required 0 1", ex.name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || hit !== 1'b0 || degenerate !== 1'b0) begin
            errors++;
            $display("FAIL reset: ir=%b ov=%b hit=%b deg=%b required 1 0 0 0",
                     in_ready, out_valid, hit, degenerate);
        end
    endtask

    task automatic test_directed();
        vec_t a0, a1, a2, nz;
        a0 = mk(0, 0, 0); a1 = mk(ONE, 0, 0); a2 = mk(0, ONE, 0); nz = mk(0, 0, ONE);
        do_txn(mk(QTR, QTR, 0), a0, a1, a2, nz, 1, 0, 27, "inside", 0, 0);
        do_txn(mk(HLF, -ONE, 0), a0, a1, a2, nz, 0, 0, 9, "out_e0", 0, 0);
        do_txn(mk(ONE * 2, ONE * 2, 0), a0, a1, a2, nz, 0, 0, 18, "out_e1", 0, 0);
        do_txn(mk(HLF, 0, 0), a0, a1, a2, nz, 1, 0, 27, "on_edge", 0, 0);
        // Vertex: edges 0 and 2 give d==0 but edge 1 is positive, so it is an inside point
        do_txn(mk(0, 0, 0), a0, a1, a2, nz, 1, 0, 27, "vertex", 0, 0);
        do_txn(mk(QTR, QTR, 0), a0, a1, a2, mk(0, 0, 0), 0, 1, 27, "zero_n", 0, 0);
        do_txn(mk(QTR, QTR, 0), a0, mk(ONE, ONE, 0), mk(ONE * 2, ONE * 2, 0), nz, 0, 1, 27, "collin", 0, 0);
    endtask

    task automatic test_random();
        vec_t pp, a0, a1, a2, nn;
        bit h, dg;
        int lat;
        for (int t = 0; t < 12; t++) begin
            pp = mk(32'($urandom_range(0, 32'h40000)) - 32'h20000,
                    32'($urandom_range(0, 32'h40000)) - 32'h20000, 0);
            if (t < 6) begin
                a0 = mk(0, 0, 0); a1 = mk(ONE, 0, 0); a2 = mk(0, ONE, 0);
                nn = mk(0, 0, (t % 2) ? ONE : -ONE);
            end else begin
                a0 = mk(32'($urandom_range(0, 32'h30000)) - 32'h18000, 32'($urandom_range(0, 32'h30000)) - 32'h18000, QTR);
                a1 = mk(32'($urandom_range(0, 32'h30000)) - 32'h18000, 32'($urandom_range(0, 32'h30000)) - 32'h18000, 0);
                a2 = mk(32'($urandom_range(0, 32'h30000)) - 32'h18000, 32'($urandom_range(0, 32'h30000)) - 32'h18000, HLF);
                nn = mk(32'($urandom_range(0, 32'h20000)) - 32'h10000, 32'($urandom_range(0, 32'h20000)) - 32'h10000, ONE);
            end
            model(pp, a0, a1, a2, nn, h, dg, lat);
            do_txn(pp, a0, a1, a2, nn, h, dg, lat, $sformatf("rand%0d", t), 0, 0);
        end
    endtask

    task automatic test_backpressure();
        do_txn(mk(QTR, QTR, 0), mk(0, 0, 0), mk(ONE, 0, 0), mk(0, ONE, 0), mk(0, 0, ONE),
               1, 0, 27, "bp_hit", 5, 1);
        do_txn(mk(HLF, -ONE, 0), mk(0, 0, 0), mk(ONE, 0, 0), mk(0, ONE, 0), mk(0, 0, ONE),
               0, 0, 9, "bp_miss", 5, 0);
        // The in_valid held across the release edge must not have started a job
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_noaccept: ir=%b ov=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        p = mk(QTR, QTR, 0); v0 = mk(0, 0, 0); v1 = mk(ONE, 0, 0); v2 = mk(0, ONE, 0); n = mk(0, 0, ONE);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 13; i++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || hit !== 1'b0 || degenerate !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: ir=%b ov=%b hit=%b deg=%b required 1 0 0 0",
                     in_ready, out_valid, hit, degenerate);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_noout: out_valid=1 after abort required 0");
        end
        do_txn(mk(QTR, QTR, 0), mk(0, 0, 0), mk(ONE, 0, 0), mk(0, ONE, 0), mk(0, 0, ONE),
               1, 0, 27, "post_rst", 0, 0);
    endtask

    initial begin
        p = '0; v0 = '0; v1 = '0; v2 = '0; n = '0;
        #23;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
